// File: rtl/ifu_pkg.sv
// Shared types and constants for the RV64 NPC instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } ifu_state_e;

  localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ifu_pc.sv
// Program counter register: redirect beats advance, otherwise hold.
module ifu_pc
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target & ~XLEN'(3);
    end else if (advance) begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch with redirect support.
// Optional IFU_EBREAK_HALT_EN: accepting an ebreak stops fetch until reset.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            halted
);

  ifu_state_e      state;
  logic            drop;
  logic [XLEN-1:0] pc;
  logic            redirect_en;
  logic            advance;

  assign redirect_en   = redirect_valid && (state != HALT);
  assign advance       = (state == HOLD) && inst_ready;
  assign imem_req_addr = pc;

  ifu_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (advance),
    .redirect (redirect_en),
    .target   (redirect_pc),
    .pc       (pc)
  );

`ifndef IFU_EBREAK_HALT_EN
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= REQ;
      drop           <= 1'b0;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst           <= NOP_INST;
      inst_pc        <= RESET_PC;
`ifdef IFU_EBREAK_HALT_EN
      halted         <= 1'b0;
`endif
    end else begin
      case (state)
        REQ: begin
          // A redirect coinciding with acceptance still owes the memory a
          // response, so wait for it and throw it away.
          if (imem_req_valid && imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
            drop           <= redirect_en;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            drop <= 1'b0;
            if (drop || redirect_en) begin
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end else begin
              inst       <= imem_resp_data;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end else if (redirect_en) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_en) begin
            inst_valid     <= 1'b0;
            state          <= REQ;
            imem_req_valid <= 1'b1;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
`ifdef IFU_EBREAK_HALT_EN
            if (inst == EBREAK_INST) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end
`else
            state          <= REQ;
            imem_req_valid <= 1'b1;
`endif
          end
        end
`ifdef IFU_EBREAK_HALT_EN
        HALT: ;
`endif
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized self-checking bench for ifu_fetch against a transaction-level PC model.
module tb_ifu_fetch;
  import ifu_pkg::*;

  localparam int          XLEN        = 64;
  localparam logic [63:0] RST_PC      = 64'h0000_0000_8000_0000;
  localparam logic [63:0] EBREAK_ADDR = 64'h0000_1234_0000_0100;

  logic            clk;
  logic            rst_n;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            halted;

  ifu_fetch #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural fetch PC and halt flag.
  logic [63:0] model_pc;
  bit          model_halted;

  // Memory model: one pending read with a countdown.
  bit          mem_busy;
  int          mem_cnt;
  logic [63:0] mem_addr;
  bit          stale_resp;
  int          mem_lat_min;
  int          mem_lat_max;

  bit          prev_hold;
  logic [31:0] prev_inst;
  logic [63:0] prev_pc;
  int          idle;
  bit          acc_seen;
  logic [63:0] last_acc_addr;
  int          hs_count;
  logic [63:0] last_hs_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == EBREAK_ADDR) return EBREAK_INST;
    return a[31:0];
  endfunction

  // Called at a falling edge: check outputs, drive inputs, advance the model.
  task automatic cycle(input bit rq_rdy, input bit in_rdy, input bit redir, input logic [63:0] tgt);
    bit acc, hs, rv;
    check("halted", halted, model_halted);
    if (model_halted) begin
      check("halt_no_req", imem_req_valid, 0);
      check("halt_no_inst", inst_valid, 0);
    end
    if (inst_valid) check("no_req_in_hold", imem_req_valid, 0);
    if (prev_hold) begin
      check("hold_valid", inst_valid, 1);
      check("hold_inst", inst, prev_inst);
      check("hold_pc", inst_pc, prev_pc);
    end

    rv = 1'b0;
    if (stale_resp) begin
      rv = 1'b1;
      imem_resp_data = 32'hdead_beef;
      stale_resp = 1'b0;
    end else if (mem_busy && mem_cnt == 0) begin
      rv = 1'b1;
      imem_resp_data = mem_word(mem_addr);
      mem_busy = 1'b0;
    end else begin
      imem_resp_data = $urandom;
      if (mem_busy) mem_cnt--;
    end
    imem_resp_valid = rv;
    imem_req_ready  = rq_rdy;
    inst_ready      = in_rdy;
    redirect_valid  = redir;
    redirect_pc     = redir ? tgt : {$urandom, $urandom};

    acc = imem_req_valid && rq_rdy;
    hs  = inst_valid && in_rdy;
    if (acc) begin
      check("one_outstanding", mem_busy, 0);
      check("req_addr", imem_req_addr, model_pc);
      mem_busy      = 1'b1;
      mem_cnt       = $urandom_range(mem_lat_max - 1, mem_lat_min - 1);
      mem_addr      = imem_req_addr;
      acc_seen      = 1'b1;
      last_acc_addr = imem_req_addr;
    end
    if (hs) begin
      check("inst_pc", inst_pc, model_pc);
      check("inst", inst, mem_word(model_pc));
      hs_count++;
      last_hs_pc = inst_pc;
    end

    if (!model_halted) begin
      if (redir) begin
        model_pc = tgt & ~64'h3;
      end else if (hs) begin
`ifdef IFU_EBREAK_HALT_EN
        if (mem_word(model_pc) == EBREAK_INST) model_halted = 1'b1;
`endif
        model_pc = model_pc + 64'd4;
      end
    end

    prev_hold = inst_valid && !in_rdy && !redir;
    prev_inst = inst;
    prev_pc   = inst_pc;

    if (acc || hs || model_halted) idle = 0;
    else idle++;
    if (idle > 200) begin
      check("stall_timeout", idle, 0);
      idle = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold_cycles, input bit stale);
    rst_n = 1'b0;
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b0;
    #1;
    check("rst_inst_valid", inst_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst", inst, NOP_INST);
    check("rst_inst_pc", inst_pc, RST_PC);
    check("rst_halted", halted, 0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    repeat (hold_cycles) @(negedge clk);
    model_pc     = RST_PC;
    model_halted = 1'b0;
    mem_busy     = 1'b0;
    stale_resp   = stale;
    prev_hold    = 1'b0;
    idle         = 0;
    rst_n        = 1'b1;
  endtask

  task automatic run_until_accept(input bit in_rdy);
    int n;
    n = 0;
    acc_seen = 1'b0;
    while (!acc_seen && n < 50) begin
      cycle(1'b1, in_rdy, 1'b0, 64'd0);
      n++;
    end
    if (!acc_seen) check("accept_timeout", n, 0);
  endtask

  task automatic run_until_valid();
    int n;
    n = 0;
    while (!inst_valid && n < 50) begin
      cycle(1'b1, 1'b0, 1'b0, 64'd0);
      n++;
    end
    if (!inst_valid) check("valid_timeout", n, 0);
  endtask

  task automatic run_handshakes(input int count);
    int n, target;
    n = 0;
    target = hs_count + count;
    while (hs_count < target && n < 100) begin
      cycle(1'b1, 1'b1, 1'b0, 64'd0);
      n++;
    end
    if (hs_count < target) check("handshake_timeout", n, 0);
  endtask

  initial begin
    int          first_valid, n;
    logic [63:0] held_pc, tgt;
    bit          rq, ir, rd;

    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
    mem_lat_min = 1; mem_lat_max = 1;
    hs_count = 0; acc_seen = 1'b0; last_acc_addr = '0; last_hs_pc = '0;
    prev_inst = '0; prev_pc = '0;
    @(negedge clk);

    // Reset and sequential fetch with 1-cycle memory.
    do_reset(2, 1'b0);
    first_valid = -1;
    n = 0;
    while (hs_count < 3 && n < 30) begin
      if (inst_valid && first_valid < 0) first_valid = n;
      cycle(1'b1, 1'b1, 1'b0, 64'd0);
      n++;
    end
    check("first_valid_latency", first_valid, 3);
    check("third_fetch_pc", last_hs_pc, 64'h8000_0008);

    // Decode back-pressure.
    run_until_valid();
    held_pc = inst_pc;
    for (int i = 0; i < 5; i++) begin
      check("bp_pc_held", imem_req_addr, held_pc);
      cycle(1'b1, 1'b0, 1'b0, 64'd0);
    end
    cycle(1'b1, 1'b1, 1'b0, 64'd0);
    check("bp_pc_advanced", imem_req_addr, held_pc + 64'd4);

    // Redirect while a response is pending; response lands two cycles later.
    mem_lat_min = 3; mem_lat_max = 3;
    run_until_accept(1'b1);
    cycle(1'b0, 1'b1, 1'b1, 64'h8000_0100);
    for (int i = 0; i < 4; i++) begin
      check("drop_no_valid", inst_valid, 0);
      cycle(1'b0, 1'b1, 1'b0, 64'd0);
    end
    run_until_accept(1'b1);
    check("redirect_wait_addr", last_acc_addr, 64'h8000_0100);

    // Redirect together with the decode handshake.
    mem_lat_min = 1; mem_lat_max = 2;
    run_until_valid();
    cycle(1'b1, 1'b1, 1'b1, 64'h8000_0042);
    run_until_accept(1'b1);
    check("redirect_hold_addr", last_acc_addr, 64'h8000_0040);

    // PC wraps past the top of the address space.
    cycle(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_handshakes(2);
    check("pc_wrap", last_hs_pc, 64'd0);

    // Reset in WAIT with a stale response arriving just after release.
    mem_lat_min = 3; mem_lat_max = 3;
    run_until_accept(1'b1);
    do_reset(2, 1'b1);
    run_until_accept(1'b1);
    check("post_reset_addr", last_acc_addr, RST_PC);
    run_handshakes(1);
    check("post_reset_inst_pc", last_hs_pc, RST_PC);

    // Reset while an instruction is held.
    run_until_valid();
    do_reset(1, 1'b0);

    // Randomized traffic with occasional resets.
    mem_lat_min = 1; mem_lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset(1, 1'b0);
      rq = ($urandom_range(0, 99) < 60);
      ir = ($urandom_range(0, 99) < 50);
      rd = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 2))
        0:       tgt = RST_PC + 64'($urandom_range(0, 1023));
        1:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        default: tgt = {$urandom, $urandom};
      endcase
      cycle(rq, ir, rd, tgt);
    end

    // ebreak: halts when the feature is built, otherwise fetched normally.
    do_reset(1, 1'b0);
    mem_lat_min = 1; mem_lat_max = 2;
    cycle(1'b1, 1'b1, 1'b1, EBREAK_ADDR);
`ifdef IFU_EBREAK_HALT_EN
    n = 0;
    while (!model_halted && n < 50) begin
      cycle(1'b1, 1'b1, 1'b0, 64'd0);
      n++;
    end
    cycle(1'b1, 1'b1, 1'b0, 64'd0);
    check("ebreak_halted", halted, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, ($urandom_range(0, 1) == 1), RST_PC);
    end
    check("halt_req_off", imem_req_valid, 0);
`else
    run_handshakes(3);
    check("ebreak_no_halt", halted, 0);
    check("ebreak_fetch_continues", last_hs_pc, EBREAK_ADDR + 64'd8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
